axi4_lite_reg_slave: RTL and testbench
======================================

AXI4_LITE_REG_SLAVE -- requirements
Module: axi4_lite_reg_slave

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_1020: byte address of register 0.
REQ-002 SHALL have parameter NUM_REGS, default 4: number of 32-bit registers, power of two, 2..16.
REQ-003 SHALL have port clk, input, 1: clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port axi, modport, axi4_lite_if.slave: AXI4-Lite responder using aw*/w*/b*/ar*/r* channels, 32-bit address and data, 4-bit wstrb.
REQ-006 SHALL have port reg_q, output, NUM_REGS*32: live register contents; register i occupies bits [32i+31:32i].
REQ-007 SHALL have port err_count, output, 8: saturating count of out-of-range accesses.

Function
REQ-008 SHALL decode an address as in range when address bits [31:log2(NUM_REGS)+2] equal the same bits of BASE_ADDR; index = address bits [log2(NUM_REGS)+1:2]; bits [1:0] ignored.
REQ-009 Write FSM SHALL use states W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP.
REQ-010 awready SHALL be 1 in W_IDLE and W_HAVE_DATA and 0 otherwise; wready SHALL be 1 in W_IDLE and W_HAVE_ADDR and 0 otherwise.
REQ-011 W_IDLE: AW-only handshake -> W_HAVE_ADDR; W-only handshake -> W_HAVE_DATA; both in the same cycle -> W_RESP.
REQ-012 W_HAVE_ADDR with W handshake -> W_RESP; W_HAVE_DATA with AW handshake -> W_RESP.
REQ-013 On the edge entering W_RESP, an in-range write SHALL update each byte lane k of the target register where wstrb[k]=1; lanes with wstrb[k]=0 and out-of-range writes SHALL leave all registers unchanged.
REQ-014 bvalid SHALL be 1 exactly in W_RESP and held until bready; on the bvalid&&bready edge -> W_IDLE.
REQ-015 Write latency: AW and W accepted in cycle N -> bvalid in cycle N+1; bready held high -> awready/wready back in cycle N+2.
REQ-016 Read FSM SHALL use states R_IDLE and R_DATA; arready = 1 only in R_IDLE.
REQ-017 On the AR handshake edge, the block SHALL register rdata = the addressed register (0 when out of range) and rresp, then enter R_DATA.
REQ-018 rvalid SHALL be 1 exactly in R_DATA; rdata and rresp SHALL be stable until rready; on the rvalid&&rready edge -> R_IDLE.
REQ-019 Read latency: AR accepted in cycle N -> rvalid in cycle N+1.
REQ-020 Read and write FSMs SHALL run independently.
REQ-021 When a read samples on the same edge a write commits to the same register, the read SHALL return the pre-write value.
REQ-022 err_count SHALL increment once per out-of-range write (on entering W_RESP) and once per out-of-range read (on AR handshake), saturate at 8'hFF, and add 2 when both occur on the same edge.

Reset
REQ-023 While rst=1 at a clock edge: all registers = 0, err_count = 0, both FSMs idle, awready = wready = arready = 1, bvalid = rvalid = 0, bresp = rresp = 2'b00, rdata = 0.
REQ-024 Reset mid-transaction SHALL discard any captured address or data and any pending response without updating registers.

Configuration
REQ-025 Macro AXI_REG_SLAVE_SLVERR_EN: when defined, out-of-range accesses SHALL return bresp/rresp = 2'b10 (SLVERR).
REQ-026 When AXI_REG_SLAVE_SLVERR_EN is undefined, out-of-range accesses SHALL return 2'b00 (OKAY); err_count behaviour is unchanged.

Verification
REQ-027 AW+W to 0x1024 with data 0xDEADBEEF and wstrb 4'hF in the same cycle -> bvalid next cycle with bresp 00; read of 0x1024 -> rdata 0xDEADBEEF one cycle after AR.
REQ-028 W with data 0xCAFEBABE issued 3 cycles before AW to 0x1028 -> W accepted, awready still 1 during the gap, bvalid the cycle after AW; reg_q[95:64] = 0xCAFEBABE.
REQ-029 Register at 0x102C holds 0xFFFFFFFF; write 0x00000000 with wstrb 4'b0101 -> register reads 0xFF00FF00.
REQ-030 Write and read to 0x2000 -> registers unchanged, err_count = 2, rdata = 0; resp = 2'b10 with the macro defined and 2'b00 without it.
REQ-031 bready held low 10 cycles -> bvalid held, awready/wready stay 0; meanwhile an AR to 0x1020 completes normally.
REQ-032 rst asserted in W_HAVE_ADDR after AW to 0x1020 -> after reset a W-only beat moves the FSM to W_HAVE_DATA, and 0x1020 is not written until a new AW arrives.

Source files
------------

// File: rtl/axi4_lite_reg_slave_if.sv
// -----------------------------------------------------------------------------
// axi4_lite_if
//   AXI4-Lite bundle carrying the five channels with 32-bit address and data
//   and a 4-bit write strobe. No clock or reset travels with the bundle; the
//   endpoints supply their own.
//
//   slave  modport : responder side (accepts AW/W/AR, produces B/R)
//   master modport : requester side
// -----------------------------------------------------------------------------
interface axi4_lite_if;

  // Write address channel
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;

  // Write data channel
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;

  // Write response channel
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  // Read address channel
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;

  // Read data channel
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport slave (
    input  awaddr, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );

  modport master (
    output awaddr, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

endinterface : axi4_lite_if

// File: rtl/axi4_lite_reg_slave.sv
// -----------------------------------------------------------------------------
// axi4_lite_reg_slave
//   AXI4-Lite responder exposing NUM_REGS 32-bit read/write registers starting
//   at byte address BASE_ADDR. Write and read paths are independent FSMs.
//   Writes honour byte strobes; accesses that miss the register window leave
//   the registers untouched, read back as zero and bump a saturating error
//   counter.
//
//   Build option:
//     AXI_REG_SLAVE_SLVERR_EN  defined   -> out-of-range accesses answer SLVERR
//                              undefined -> out-of-range accesses answer OKAY
//
//   Parameters:
//     BASE_ADDR  byte address of register 0 (aligned to the window size)
//     NUM_REGS   register count, power of two, 2..16
//
//   Ports:
//     clk        clock, rising edge
//     rst        synchronous active-high reset
//     axi        AXI4-Lite slave modport
//     reg_q      live register contents, register i at [32i+31:32i]
//     err_count  saturating count of out-of-range accesses
// -----------------------------------------------------------------------------
module axi4_lite_reg_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1020,
  parameter int          NUM_REGS  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  axi4_lite_if.slave               axi,
  output logic [NUM_REGS*32-1:0]   reg_q,
  output logic [7:0]               err_count
);

  localparam int IDX_W   = $clog2(NUM_REGS);
  localparam int TAG_LSB = IDX_W + 2;

  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXI_REG_SLAVE_SLVERR_EN
  localparam logic [1:0] RESP_MISS = 2'b10;
`else
  localparam logic [1:0] RESP_MISS = 2'b00;
`endif

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_ADDR,
    W_HAVE_DATA,
    W_RESP
  } w_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_t;

  // Address decode: the tag bits above the register index must match the base.
  function automatic logic addr_hit(input logic [31:0] addr);
    return addr[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] addr);
    return addr[TAG_LSB-1:2];
  endfunction

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [NUM_REGS-1:0][31:0] regs_q;
  logic [7:0]                err_q;

  assign reg_q     = regs_q;
  assign err_count = err_q;

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------
  w_state_t       w_state, w_next;
  logic           aw_hs, w_hs, wr_commit;
  logic [31:0]    aw_addr_q, w_data_q;
  logic [3:0]     w_strb_q;
  logic [31:0]    wr_addr, wr_data;
  logic [3:0]     wr_strb;
  logic           wr_hit;
  logic [IDX_W-1:0] wr_idx;
  logic [1:0]     bresp_q;

  // NOTE: every output of a combinational block gets a default before the
  // case statement, so no path through it can leave a value unassigned and
  // infer a latch.
  always_comb begin
    w_next      = w_state;
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.bvalid  = 1'b0;
    aw_hs       = 1'b0;
    w_hs        = 1'b0;

    case (w_state)
      W_IDLE: begin
        axi.awready = 1'b1;
        axi.wready  = 1'b1;
        aw_hs       = axi.awvalid;
        w_hs        = axi.wvalid;
        if (axi.awvalid && axi.wvalid) w_next = W_RESP;
        else if (axi.awvalid)          w_next = W_HAVE_ADDR;
        else if (axi.wvalid)           w_next = W_HAVE_DATA;
      end
      W_HAVE_ADDR: begin
        axi.wready = 1'b1;
        w_hs       = axi.wvalid;
        if (axi.wvalid) w_next = W_RESP;
      end
      W_HAVE_DATA: begin
        axi.awready = 1'b1;
        aw_hs       = axi.awvalid;
        if (axi.awvalid) w_next = W_RESP;
      end
      W_RESP: begin
        axi.bvalid = 1'b1;
        if (axi.bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase

    // The write takes effect on the edge that enters W_RESP.
    wr_commit = (w_state != W_RESP) && (w_next == W_RESP);
  end

  // The half that arrived earlier comes from its capture register; the half
  // completing the pair this cycle comes straight off the bus.
  always_comb begin
    wr_addr = (w_state == W_HAVE_ADDR) ? aw_addr_q : axi.awaddr;
    wr_data = (w_state == W_HAVE_DATA) ? w_data_q  : axi.wdata;
    wr_strb = (w_state == W_HAVE_DATA) ? w_strb_q  : axi.wstrb;
  end

  assign wr_hit = addr_hit(wr_addr);
  assign wr_idx = addr_idx(wr_addr);

  // NOTE: sequential state is assigned with non-blocking (<=) so every flop
  // samples pre-edge values; that is also what gives a read on the same edge
  // as a write the old register contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state   <= W_IDLE;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state <= w_next;
      if (aw_hs) aw_addr_q <= axi.awaddr;
      if (w_hs) begin
        w_data_q <= axi.wdata;
        w_strb_q <= axi.wstrb;
      end
      if (wr_commit) bresp_q <= wr_hit ? RESP_OKAY : RESP_MISS;
    end
  end

  assign axi.bresp = bresp_q;

  // NOTE: the register array is reset because its contents are architecturally
  // visible after reset (reg_q and read data must be zero); plain data buffers
  // without that requirement would not need it.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '0;
    end else if (wr_commit && wr_hit) begin
      for (int k = 0; k < 4; k++) begin
        if (wr_strb[k]) regs_q[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  r_state_t       r_state, r_next;
  logic           ar_hs;
  logic           rd_hit;
  logic [IDX_W-1:0] rd_idx;
  logic [31:0]    rdata_q;
  logic [1:0]     rresp_q;

  always_comb begin
    r_next      = r_state;
    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    ar_hs       = 1'b0;

    case (r_state)
      R_IDLE: begin
        axi.arready = 1'b1;
        ar_hs       = axi.arvalid;
        if (axi.arvalid) r_next = R_DATA;
      end
      R_DATA: begin
        axi.rvalid = 1'b1;
        if (axi.rready) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  assign rd_hit = addr_hit(axi.araddr);
  assign rd_idx = addr_idx(axi.araddr);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else begin
      r_state <= r_next;
      if (ar_hs) begin
        rdata_q <= rd_hit ? regs_q[rd_idx] : 32'h0;
        rresp_q <= rd_hit ? RESP_OKAY : RESP_MISS;
      end
    end
  end

  assign axi.rdata = rdata_q;
  assign axi.rresp = rresp_q;

  // ---------------------------------------------------------------------------
  // Out-of-range counter: a write miss and a read miss on the same edge add 2.
  // ---------------------------------------------------------------------------
  logic       wr_miss, rd_miss;
  logic [1:0] err_inc;
  logic [8:0] err_sum;

  assign wr_miss = wr_commit && !wr_hit;
  assign rd_miss = ar_hs && !rd_hit;
  assign err_inc = {1'b0, wr_miss} + {1'b0, rd_miss};
  assign err_sum = {1'b0, err_q} + {7'b0, err_inc};

  always_ff @(posedge clk) begin
    if (rst) err_q <= '0;
    else     err_q <= err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  // ---------------------------------------------------------------------------
  // Protocol properties: responses hold until accepted.
  // ---------------------------------------------------------------------------
  a_b_hold : assert property (@(posedge clk) disable iff (rst)
    axi.bvalid && !axi.bready |=> axi.bvalid && $stable(axi.bresp));

  a_r_hold : assert property (@(posedge clk) disable iff (rst)
    axi.rvalid && !axi.rready |=> axi.rvalid && $stable(axi.rdata) && $stable(axi.rresp));

  a_no_accept_while_resp : assert property (@(posedge clk) disable iff (rst)
    axi.bvalid |-> !axi.awready && !axi.wready);

endmodule : axi4_lite_reg_slave

// File: tb/tb_axi4_lite_reg_slave.sv
// -----------------------------------------------------------------------------
// tb_axi4_lite_reg_slave
//   Directed bench for axi4_lite_reg_slave with a scoreboard: each issued write
//   or read pushes its expected response; a negedge monitor pops and compares
//   whenever a B or R beat is accepted. Register contents, latency and
//   err_count are checked directly by the stimulus thread.
// -----------------------------------------------------------------------------
module tb_axi4_lite_reg_slave;

  localparam logic [1:0] OKAY = 2'b00;
`ifdef AXI_REG_SLAVE_SLVERR_EN
  localparam logic [1:0] ERR_RESP = 2'b10;
`else
  localparam logic [1:0] ERR_RESP = 2'b00;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } r_exp_t;

  logic         clk;
  logic         rst;
  logic [127:0] reg_q;
  logic [7:0]   err_count;

  axi4_lite_if axi ();

  axi4_lite_reg_slave #(
    .BASE_ADDR (32'h0000_1020),
    .NUM_REGS  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .axi       (axi),
    .reg_q     (reg_q),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] exp_b[$];
  r_exp_t     exp_r[$];
  logic [1:0] mon_b;
  r_exp_t     mon_r;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: inputs change #1 after posedge, so the negedge sees the values
  // that the following posedge will use for the handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (axi.bvalid && axi.bready) begin
        check("b_expected_present", 128'(exp_b.size() != 0), 128'd1);
        if (exp_b.size() != 0) begin
          mon_b = exp_b.pop_front();
          check("bresp", axi.bresp, mon_b);
        end
      end
      if (axi.rvalid && axi.rready) begin
        check("r_expected_present", 128'(exp_r.size() != 0), 128'd1);
        if (exp_r.size() != 0) begin
          mon_r = exp_r.pop_front();
          check("rdata", axi.rdata, mon_r.data);
          check("rresp", axi.rresp, mon_r.resp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_aw(input logic [31:0] a);
    axi.awaddr  = a;
    axi.awvalid = 1'b1;
  endtask

  task automatic drive_w(input logic [31:0] d, input logic [3:0] s);
    axi.wdata  = d;
    axi.wstrb  = s;
    axi.wvalid = 1'b1;
  endtask

  task automatic drive_ar(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
    axi.araddr  = a;
    axi.arvalid = 1'b1;
    exp_r.push_back('{data: d, resp: resp});
  endtask

  task automatic drop_valids();
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    axi.arvalid = 1'b0;
  endtask

  // Bounded wait for both FSMs to be idle.
  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      if (axi.awready && axi.wready && axi.arready && !axi.bvalid && !axi.rvalid) break;
      tick();
    end
    check("wait_idle", {axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid}, 5'b11100);
  endtask

  // AW and W in the same cycle; bvalid must follow one cycle later and the
  // channel must be ready again one cycle after that.
  task automatic write_full(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [1:0] resp);
    wait_idle();
    drive_aw(a);
    drive_w(d, s);
    exp_b.push_back(resp);
    tick();
    drop_valids();
    check("wr_latency_bvalid", axi.bvalid, 1'b1);
    tick();
    check("wr_ready_back", {axi.awready, axi.wready, axi.bvalid}, 3'b110);
  endtask

  task automatic read_check(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
    wait_idle();
    drive_ar(a, d, resp);
    tick();
    drop_valids();
    check("rd_latency_rvalid", axi.rvalid, 1'b1);
    tick();
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst         = 1'b1;
    axi.awaddr  = '0;
    axi.awvalid = 1'b0;
    axi.wdata   = '0;
    axi.wstrb   = '0;
    axi.wvalid  = 1'b0;
    axi.bready  = 1'b1;
    axi.araddr  = '0;
    axi.arvalid = 1'b0;
    axi.rready  = 1'b1;

    tick();
    tick();
    check("rst_readies", {axi.awready, axi.wready, axi.arready}, 3'b111);
    check("rst_valids", {axi.bvalid, axi.rvalid}, 2'b00);
    check("rst_resps", {axi.bresp, axi.rresp}, 4'b0000);
    check("rst_rdata", axi.rdata, 32'h0);
    check("rst_reg_q", reg_q, 128'h0);
    check("rst_err_count", err_count, 8'h00);
    rst = 1'b0;
    tick();

    // Combined AW+W then read back.
    write_full(32'h0000_1024, 32'hDEAD_BEEF, 4'hF, OKAY);
    check("t1_reg1", reg_q[63:32], 32'hDEAD_BEEF);
    read_check(32'h0000_1024, 32'hDEAD_BEEF, OKAY);

    // W leads AW by three cycles.
    wait_idle();
    drive_w(32'hCAFE_BABE, 4'hF);
    tick();
    drop_valids();
    for (int i = 0; i < 3; i++) begin
      check("t2_have_data", {axi.awready, axi.wready, axi.bvalid}, 3'b100);
      if (i < 2) tick();
    end
    drive_aw(32'h0000_1028);
    exp_b.push_back(OKAY);
    tick();
    drop_valids();
    check("t2_bvalid_after_aw", axi.bvalid, 1'b1);
    check("t2_reg2", reg_q[95:64], 32'hCAFE_BABE);
    tick();

    // Partial strobe: bytes 0 and 2 cleared.
    write_full(32'h0000_102C, 32'hFFFF_FFFF, 4'hF, OKAY);
    write_full(32'h0000_102C, 32'h0000_0000, 4'b0101, OKAY);
    check("t3_reg3", reg_q[127:96], 32'hFF00_FF00);
    read_check(32'h0000_102C, 32'hFF00_FF00, OKAY);

    // Out-of-range write and read.
    write_full(32'h0000_2000, 32'h1234_5678, 4'hF, ERR_RESP);
    check("t4_regs_unchanged", reg_q, {32'hFF00_FF00, 32'hCAFE_BABE, 32'hDEAD_BEEF, 32'h0});
    check("t4_err_after_wr", err_count, 8'd1);
    read_check(32'h0000_2000, 32'h0, ERR_RESP);
    check("t4_err_after_rd", err_count, 8'd2);

    // B stalled 10 cycles while a read goes through.
    axi.bready = 1'b0;
    wait_idle();
    drive_aw(32'h0000_1020);
    drive_w(32'h1111_2222, 4'hF);
    exp_b.push_back(OKAY);
    tick();
    drop_valids();
    for (int i = 0; i < 10; i++) begin
      check("t5_b_hold", {axi.bvalid, axi.awready, axi.wready}, 3'b100);
      if (i == 2) drive_ar(32'h0000_1020, 32'h1111_2222, OKAY);
      if (i == 3) begin
        drop_valids();
        check("t5_rvalid_during_stall", axi.rvalid, 1'b1);
      end
      tick();
    end
    axi.bready = 1'b1;
    tick();
    check("t5_released", {axi.bvalid, axi.awready, axi.wready}, 3'b011);

    // Read and write to the same register on the same edge.
    wait_idle();
    drive_aw(32'h0000_1024);
    drive_w(32'h5555_5555, 4'hF);
    exp_b.push_back(OKAY);
    drive_ar(32'h0000_1024, 32'hDEAD_BEEF, OKAY);
    tick();
    drop_valids();
    check("t6_both_valid", {axi.bvalid, axi.rvalid}, 2'b11);
    tick();
    read_check(32'h0000_1024, 32'h5555_5555, OKAY);

    // AW leads W; upper two bytes only.
    wait_idle();
    drive_aw(32'h0000_1020);
    tick();
    drop_valids();
    check("t7_have_addr", {axi.awready, axi.wready}, 2'b01);
    drive_w(32'hA5A5_0000, 4'b1100);
    exp_b.push_back(OKAY);
    tick();
    drop_valids();
    check("t7_bvalid", axi.bvalid, 1'b1);
    tick();
    check("t7_reg0", reg_q[31:0], 32'hA5A5_2222);
    read_check(32'h0000_1020, 32'hA5A5_2222, OKAY);

    // Simultaneous misses add 2; then run into saturation.
    for (int i = 0; i < 130; i++) begin
      wait_idle();
      drive_aw(32'h0000_3000);
      drive_w(32'h0BAD_F00D, 4'hF);
      exp_b.push_back(ERR_RESP);
      drive_ar(32'h0000_3004, 32'h0, ERR_RESP);
      tick();
      drop_valids();
      if (i == 0) check("t8_err_plus2", err_count, 8'd4);
      tick();
    end
    check("t8_err_saturated", err_count, 8'hFF);
    check("t8_regs_unchanged", reg_q, {32'hFF00_FF00, 32'hCAFE_BABE, 32'h5555_5555, 32'hA5A5_2222});

    // Reset while holding a captured address.
    wait_idle();
    drive_aw(32'h0000_1020);
    tick();
    drop_valids();
    check("t9_have_addr", {axi.awready, axi.wready}, 2'b01);
    rst = 1'b1;
    tick();
    check("t9_rst_reg_q", reg_q, 128'h0);
    check("t9_rst_err", err_count, 8'h00);
    check("t9_rst_readies", {axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid}, 5'b11100);
    tick();
    rst = 1'b0;
    drive_w(32'h7777_7777, 4'hF);
    tick();
    drop_valids();
    check("t9_have_data", {axi.awready, axi.wready, axi.bvalid}, 3'b100);
    check("t9_reg0_untouched", reg_q[31:0], 32'h0);
    tick();
    tick();
    check("t9_still_waiting", {axi.bvalid, axi.awready}, 2'b01);
    check("t9_reg0_still_zero", reg_q[31:0], 32'h0);
    drive_aw(32'h0000_1020);
    exp_b.push_back(OKAY);
    tick();
    drop_valids();
    check("t9_bvalid", axi.bvalid, 1'b1);
    check("t9_reg0_written", reg_q[31:0], 32'h7777_7777);
    tick();

    tick();
    check("b_queue_drained", 128'(exp_b.size()), 128'd0);
    check("r_queue_drained", 128'(exp_r.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_axi4_lite_reg_slave
